// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths and block-entry type for the fetch buffer
package fetch_pkg;
  localparam int BLOCK_WIDTH = 256;
  localparam int INSTR_WIDTH = 32;
  localparam int PC_WIDTH = 16;
  localparam int SLOTS = BLOCK_WIDTH / INSTR_WIDTH;
  localparam int SLOT_W = $clog2(SLOTS);
  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [BLOCK_WIDTH-1:0] data;
    logic [SLOT_W-1:0] start_slot;
  } entry_t;
endpackage

// File: rtl/fetch_block_fifo.sv
// fetch_block_fifo: DEPTH-entry block store with pointers, occupancy and flush
module fetch_block_fifo import fetch_pkg::*; #(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic            flush,
  input  entry_t          wr_entry,
  output entry_t          head,
  output logic [SLOT_W-1:0] next_slot,
  output logic            full,
  output logic            empty,
  output logic [AW:0]     count
);
  entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign head = mem[rd_ptr];
  assign next_slot = mem[rd_ptr + 1'b1].start_slot;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_entry;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/fetch_buffer.sv
// fetch_buffer: buffers cache blocks and issues one 32-bit instruction per cycle to decode
module fetch_buffer import fetch_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     enable_i,
  input  logic [PC_WIDTH-1:0]      blockPC_i,
  input  logic [BLOCK_WIDTH-1:0]   block_i,
  input  logic                     flush_i,
  input  logic                     decodeReady_i,
  output logic [INSTR_WIDTH-1:0]   instr_o,
  output logic [PC_WIDTH-1:0]      instrPC_o,
  output logic                     instrValid_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     overflow_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  logic [SLOT_W-1:0] s, in_slot, next_slot;
  logic pop, pop_final, push, drop, unused;
  entry_t head, wr_entry;
  assign in_slot = blockPC_i[SLOT_W+1:2];
  assign wr_entry = '{pc: blockPC_i, data: block_i, start_slot: in_slot};
  assign instrValid_o = !empty_o;
  assign pop = instrValid_o && decodeReady_i;
  assign pop_final = pop && s == SLOT_W'(SLOTS-1);
  // a full buffer still accepts when its head block retires on the same edge
  assign push = enable_i && !flush_i && (!full_o || pop_final);
  assign drop = enable_i && !flush_i && full_o && !pop_final;
  assign instr_o = head.data[s*INSTR_WIDTH +: INSTR_WIDTH];
  assign instrPC_o = {head.pc[PC_WIDTH-1:SLOT_W+2], s, 2'b00};
  assign unused = &{1'b0, head.pc[SLOT_W+1:0], head.start_slot, blockPC_i[1:0]};
  fetch_block_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clock_i),
    .rst_n(reset_i),
    .push(push),
    .pop(pop_final),
    .flush(flush_i),
    .wr_entry(wr_entry),
    .head(head),
    .next_slot(next_slot),
    .full(full_o),
    .empty(empty_o),
    .count(count_o)
  );
  // after the head retires, the next head is the older buffered block, else the one arriving now
  always_ff @(posedge clock_i or negedge reset_i)
    if (!reset_i) begin
      s <= '0;
      overflow_o <= 1'b0;
    end else begin
      overflow_o <= drop;
      s <= flush_i ? '0 :
           (empty_o && push) ? in_slot :
           !pop ? s :
           !pop_final ? s + 1'b1 :
           (count_o > 1) ? next_slot :
           push ? in_slot : '0;
    end
endmodule
